// File: rtl/vc32_pkg.sv
// Shared types for the vc32 front end: parcel/fetch-word widths, fetch FSM states
// and the parcel-buffer entry layout.
package vc32_pkg;

  localparam int PARCEL_W = 16;
  localparam int FWORD_W  = 32;
  localparam int PC_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [PARCEL_W-1:0] ins;
    logic [PC_W-1:0]     pc;
    logic                fault;
  } parcel_t;

endpackage

// File: rtl/ifetch_buf.sv
// Parcel FIFO for the fetch unit: 0/1/2 parcels pushed per cycle, one popped,
// synchronous flush. The head entry is always visible, even when the FIFO is empty.
module ifetch_buf
  import vc32_pkg::*;
#(
  parameter int      DEPTH = 2,
  parameter int      CW    = $clog2(DEPTH + 1),
  parameter parcel_t INIT  = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  parcel_t       push0,
  input  parcel_t       push1,
  input  logic          pop,
  output parcel_t       head,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  parcel_t       mem_q [DEPTH];
  logic [AW-1:0] rp_q;
  logic [AW-1:0] wp_q;
  logic [CW-1:0] count_q;

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int n);
    return AW'((int'(p) + n) % DEPTH);
  endfunction

  // Storage is reset too so the head shows a defined parcel/PC before the first fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= INIT;
      end
    end else if (flush) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_n != 2'd0) begin
        mem_q[wp_q] <= push0;
      end
      if (push_n == 2'd2) begin
        mem_q[wrap_add(wp_q, 1)] <= push1;
      end
      wp_q <= wrap_add(wp_q, int'(push_n));
      if (pop) begin
        rp_q <= wrap_add(rp_q, 1);
      end
      count_q <= CW'(int'(count_q) + int'(push_n) - (pop ? 1 : 0));
    end
  end

  assign head  = mem_q[rp_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: fetches 32-bit words, splits them into 16-bit parcels and
// feeds decode one parcel per cycle. Build option IFETCH_PREFETCH_EN: 4-deep buffer
// with overlapped fetch; otherwise 2-deep buffer with fetch and decode alternating.
module ifetch
  import vc32_pkg::*;
#(
  parameter int            RV         = 32,
  parameter logic [RV-1:0] RESET_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect,
  input  logic [RV-1:0]       redirect_pc,
  input  logic                dec_ready,
  output logic [PARCEL_W-1:0] ins,
  output logic [RV-1:0]       ins_pc,
  output logic                ins_fault,
  output logic                idone,
  output logic                mem_req,
  output logic [RV-1:0]       mem_addr,
  input  logic                mem_ack,
  input  logic [FWORD_W-1:0]  mem_rdata,
  input  logic                mem_fault
);

`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 2;
`endif
  localparam int CW = $clog2(DEPTH + 1);

  localparam parcel_t INIT_ENTRY = '{
    ins:   '0,
    pc:    PC_W'(RESET_ADDR & ~RV'(1)),
    fault: 1'b0
  };

  fetch_state_e  state_q;
  logic [RV-1:0] fpc_q;
  logic          skip_q;

  parcel_t       head;
  parcel_t       lo_e;
  parcel_t       hi_e;
  parcel_t       push0;
  logic [1:0]    push_n;
  logic [CW-1:0] count;
  logic          pop;
  logic          issue;
  logic          req_now;
  logic          accept;
  int            occ_after_pop;

  assign idone = !reset && (count != '0) && dec_ready && !redirect;
  assign pop   = idone;

  assign occ_after_pop = int'(count) - int'(pop);
`ifdef IFETCH_PREFETCH_EN
  assign issue = (DEPTH - occ_after_pop) >= 2;
`else
  assign issue = (occ_after_pop == 0);
`endif

  // A request starts combinationally from IDLE so it is visible in the first cycle
  // after reset, a redirect, or an ack; once in REQ it is held until the ack.
  assign req_now  = !reset &&
                    ((state_q == REQ) || ((state_q == IDLE) && issue && !redirect));
  assign accept   = req_now && mem_ack && !redirect;
  assign mem_req  = req_now;
  assign mem_addr = fpc_q;

  assign lo_e = '{
    ins:   mem_rdata[PARCEL_W-1:0],
    pc:    PC_W'(fpc_q),
    fault: mem_fault
  };
  assign hi_e = '{
    ins:   mem_rdata[FWORD_W-1:PARCEL_W],
    pc:    PC_W'(fpc_q + RV'(2)),
    fault: mem_fault
  };
  assign push_n = accept ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
  assign push0  = skip_q ? hi_e : lo_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fpc_q   <= RESET_ADDR & ~RV'(3);
      skip_q  <= RESET_ADDR[1];
    end else if (redirect) begin
      fpc_q  <= redirect_pc & ~RV'(3);
      skip_q <= redirect_pc[1];
      case (state_q)
        REQ, DRAIN: state_q <= mem_ack ? IDLE : DRAIN;
        default:    state_q <= IDLE;
      endcase
    end else if (accept) begin
      fpc_q   <= fpc_q + RV'(4);
      skip_q  <= 1'b0;
      state_q <= mem_fault ? HALT : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_now) state_q <= REQ;
        DRAIN:   if (mem_ack) state_q <= IDLE;
        default: ;
      endcase
    end
  end

  ifetch_buf #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .INIT  (INIT_ENTRY)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .flush  (redirect),
    .push_n (push_n),
    .push0  (push0),
    .push1  (hi_e),
    .pop    (pop),
    .head   (head),
    .count  (count)
  );

  assign ins       = head.ins;
  assign ins_pc    = RV'(head.pc);
  assign ins_fault = head.fault;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: fixed-latency memory responder, idone monitor and a
// linear sequence of redirect / fault / stall scenarios with hand-computed values.
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h100;
`ifdef IFETCH_PREFETCH_EN
  localparam int EXP_WORDS = 2;
`else
  localparam int EXP_WORDS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic [15:0] ins;
  logic [31:0] ins_pc;
  logic        ins_fault;
  logic        idone;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_fault;

  int checks = 0;
  int errors = 0;

  logic        resp_pend;
  int          resp_wait;
  logic [31:0] resp_addr;
  logic [31:0] fault_addr = 32'hFFFF_FFF0;
  int          fetch_cnt;
  logic [48:0] dq[$];

  ifetch #(.RV(32), .RESET_ADDR(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .dec_ready  (dec_ready),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_fault  (ins_fault),
    .idone      (idone),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_fault  (mem_fault)
  );

  always #5 clk = ~clk;

  // Memory image: word 0x100 holds 0x5678_1234, every other parcel encodes its own PC.
  function automatic logic [31:0] mword(input logic [31:0] a);
    if (a == 32'h100) return 32'h5678_1234;
    return {16'hC000 | {4'h0, a[11:0] + 12'h2}, 16'hC000 | {4'h0, a[11:0]}};
  endfunction

  function automatic logic [63:0] ent(input logic f, input logic [31:0] pc, input logic [15:0] i);
    return {15'b0, f, pc, i};
  endfunction

  function automatic logic [63:0] get(input int idx);
    if (idx < dq.size()) return 64'(dq[idx]);
    return 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    bit ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      next_cycle();
      redirect = 1'b0;
      settle();
      if (!mem_req && !resp_pend && !mem_ack) ok = 1'b1;
    end
    chk("quiet", 64'(ok), 64'd1);
  endtask

  // Memory responder: ack exactly 2 cycles after a request is first seen.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_fault = 1'b0;
    resp_pend = 1'b0;
    resp_wait = 0;
    resp_addr = '0;
    fetch_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      mem_ack = 1'b0;
      if (resp_pend) begin
        if (resp_wait == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mword(resp_addr);
          mem_fault = (resp_addr == fault_addr);
          resp_pend = 1'b0;
        end else begin
          resp_wait--;
        end
      end
      @(negedge clk);
      if (mem_req && !resp_pend && !mem_ack) begin
        resp_pend = 1'b1;
        resp_wait = 1;
        resp_addr = mem_addr;
        fetch_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (idone) dq.push_back({ins_fault, ins_pc, ins});
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int mark;
    int f0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b1;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_idone", 64'(idone), 64'd0);
    chk("rst_fault", 64'(ins_fault), 64'd0);
    chk("rst_ins", 64'(ins), 64'd0);
    chk("rst_pc", 64'(ins_pc), 64'(RST_PC));

    // Basic fetch after reset
    next_cycle(); reset = 1'b0; settle();
    chk("t1_req", 64'(mem_req), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h100);
    next_cycle(); settle();
    chk("t1_req_held", 64'(mem_req), 64'd1);
    chk("t1_addr_held", 64'(mem_addr), 64'h100);
    next_cycle(); settle();
    next_cycle(); settle();
    chk("t1_idone0", 64'(idone), 64'd1);
    chk("t1_ins0", 64'(ins), 64'h1234);
    chk("t1_pc0", 64'(ins_pc), 64'h100);
    chk("t1_fault0", 64'(ins_fault), 64'd0);
    next_cycle(); settle();
    chk("t1_idone1", 64'(idone), 64'd1);
    chk("t1_ins1", 64'(ins), 64'h5678);
    chk("t1_pc1", 64'(ins_pc), 64'h102);
    next_cycle(); dec_ready = 1'b0;
    wait_quiet();

    // Redirect to an odd-parcel target from IDLE
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h206; dec_ready = 1'b1; mark = dq.size(); settle();
    chk("t2_idone_redir", 64'(idone), 64'd0);
    chk("t2_noreq", 64'(mem_req), 64'd0);
    next_cycle(); redirect = 1'b0; settle();
    chk("t2_req", 64'(mem_req), 64'd1);
    chk("t2_addr", 64'(mem_addr), 64'h204);
    repeat (5) begin next_cycle(); settle(); end
    chk("t2_first", get(mark), ent(1'b0, 32'h206, 16'hC206));
    next_cycle(); dec_ready = 1'b0;
    wait_quiet();

    // Redirect while a request is outstanding
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h100; settle();
    next_cycle(); redirect = 1'b0; settle();
    chk("t3_addr_old", 64'(mem_addr), 64'h100);
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h400; dec_ready = 1'b1; mark = dq.size(); settle();
    chk("t3_req_kept", 64'(mem_req), 64'd1);
    next_cycle(); redirect = 1'b0; settle();
    chk("t3_drain", 64'(mem_req), 64'd0);
    next_cycle(); settle();
    chk("t3_req", 64'(mem_req), 64'd1);
    chk("t3_addr", 64'(mem_addr), 64'h400);
    repeat (4) begin next_cycle(); settle(); end
    chk("t3_first", get(mark), ent(1'b0, 32'h400, 16'hC400));
    next_cycle(); dec_ready = 1'b0;
    wait_quiet();

    // Redirect coincident with mem_ack
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h500; dec_ready = 1'b1; mark = dq.size(); settle();
    next_cycle(); redirect = 1'b0; settle();
    chk("t4_addr_old", 64'(mem_addr), 64'h500);
    next_cycle(); settle();
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h600; settle();
    chk("t4_idone_ack", 64'(idone), 64'd0);
    next_cycle(); redirect = 1'b0; settle();
    chk("t4_empty", 64'(idone), 64'd0);
    chk("t4_req", 64'(mem_req), 64'd1);
    chk("t4_addr", 64'(mem_addr), 64'h600);
    repeat (4) begin next_cycle(); settle(); end
    chk("t4_first", get(mark), ent(1'b0, 32'h600, 16'hC600));
    next_cycle(); dec_ready = 1'b0;
    wait_quiet();

    // Faulting fetch halts until redirected
    fault_addr = 32'h300;
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h300; dec_ready = 1'b1; mark = dq.size(); settle();
    next_cycle(); redirect = 1'b0; settle();
    chk("t5_addr", 64'(mem_addr), 64'h300);
    repeat (2) begin next_cycle(); settle(); end
    next_cycle(); settle();
    chk("t5_idone0", 64'(idone), 64'd1);
    chk("t5_ins0", 64'(ins), 64'hC300);
    chk("t5_pc0", 64'(ins_pc), 64'h300);
    chk("t5_fault0", 64'(ins_fault), 64'd1);
    chk("t5_noreq", 64'(mem_req), 64'd0);
    next_cycle(); settle();
    chk("t5_idone1", 64'(idone), 64'd1);
    chk("t5_ins1", 64'(ins), 64'hC302);
    chk("t5_fault1", 64'(ins_fault), 64'd1);
    f0 = fetch_cnt;
    repeat (10) begin next_cycle(); settle(); end
    chk("t5_halt_req", 64'(mem_req), 64'd0);
    chk("t5_nofetch", 64'(fetch_cnt), 64'(f0));
    chk("t5_count", 64'(dq.size() - mark), 64'd2);
    fault_addr = 32'hFFFF_FFF0;
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h0; settle();
    next_cycle(); redirect = 1'b0; settle();
    chk("t5_resume_req", 64'(mem_req), 64'd1);
    chk("t5_resume_addr", 64'(mem_addr), 64'h0);
    next_cycle(); dec_ready = 1'b0;
    wait_quiet();

    // Decode stalled: fetch stops once the buffer cannot take another word
    next_cycle(); redirect = 1'b1; redirect_pc = 32'h700; dec_ready = 1'b0; f0 = fetch_cnt; settle();
    next_cycle(); redirect = 1'b0; settle();
    repeat (2) begin next_cycle(); settle(); end
    for (int k = 4; k <= 12; k++) begin
      next_cycle(); settle();
      chk("t6_head", 64'(ins), 64'hC700);
    end
    chk("t6_pc", 64'(ins_pc), 64'h700);
    chk("t6_words", 64'(fetch_cnt - f0), 64'(EXP_WORDS));
    chk("t6_req_off", 64'(mem_req), 64'd0);
    chk("t6_idone", 64'(idone), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
